reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 49 ++++
 tb/tb_reg_file.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// +------------------------------------------------------------------+
// | reg_file : 32-entry register file, one write port, three         |
// |            combinational read ports (two datapath, one debug).   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module reg_file #(
  parameter int size = 32
) (
  input  logic [4:0]      readReg1,
  input  logic [4:0]      readReg2,
  input  logic [4:0]      writeReg,
  input  logic [4:0]      displayReg,
  input  logic [size-1:0] writeData,
  input  logic            clk,
  input  logic            regWrite,
  input  logic            reset,
  output logic [size-1:0] readData1,
  output logic [size-1:0] readData2,
  output logic [size-1:0] displayData
);

  localparam int c_NUM_REGS = 32;

  logic [size-1:0] r_regs [0:c_NUM_REGS-1];
  logic            w_wr_en;

  // Index 0 is never written, so it stays at its reset value of zero.
  assign w_wr_en = regWrite && (writeReg != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[writeReg] <= writeData;
    end
  end

  // Reads see the stored value only; a pending write is not forwarded.
  assign readData1   = (readReg1   == 5'd0) ? '0 : r_regs[readReg1];
  assign readData2   = (readReg2   == 5'd0) ? '0 : r_regs[readReg2];
  assign displayData = (displayReg == 5'd0) ? '0 : r_regs[displayReg];

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// Directed and randomized checks of reg_file against a behavioural model,
// with expected values queued as stimulus is applied.
`default_nettype none

module tb_reg_file;

  localparam int c_W = 32;

  logic [4:0]     readReg1, readReg2, writeReg, displayReg;
  logic [c_W-1:0] writeData;
  logic           clk, regWrite, reset;
  logic [c_W-1:0] readData1, readData2, displayData;

  reg_file #(.size(c_W)) dut (
    .readReg1    (readReg1),
    .readReg2    (readReg2),
    .writeReg    (writeReg),
    .displayReg  (displayReg),
    .writeData   (writeData),
    .clk         (clk),
    .regWrite    (regWrite),
    .reset       (reset),
    .readData1   (readData1),
    .readData2   (readData2),
    .displayData (displayData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          tag;
    int             port;
    logic [c_W-1:0] exp;
  } exp_t;

  exp_t           sb[$];
  logic [c_W-1:0] model [0:31];
  int             checks   = 0;
  int             failures = 0;

  // Update the model from the inputs present at the coming edge, then step past it.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (regWrite && writeReg != 5'd0) begin
      model[writeReg] = writeData;
    end
    #1;
  endtask

  task automatic push(input string tag, input int port, input logic [c_W-1:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic push_model(input string tag);
    push({tag, "_rd1"}, 1, model[readReg1]);
    push({tag, "_rd2"}, 2, model[readReg2]);
    push({tag, "_disp"}, 3, model[displayReg]);
  endtask

  task automatic drain();
    exp_t           e;
    logic [c_W-1:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.port)
        1:       obs = readData1;
        2:       obs = readData2;
        default: obs = displayData;
      endcase
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 'x;
    readReg1 = 0; readReg2 = 0; writeReg = 0; displayReg = 0;
    writeData = 0; regWrite = 0; reset = 1;
    @(negedge clk);
    tick();

    reset = 0; readReg1 = 1; readReg2 = 2; displayReg = 3;
    push("reset_rd1", 1, 0); push("reset_rd2", 2, 0); push("reset_disp", 3, 0);
    drain();

    // Write 12 to reg 3: invisible before the edge, visible after it.
    writeReg = 3; writeData = 12; regWrite = 1;
    push("pre_edge_disp", 3, 0);
    drain();
    tick();
    regWrite = 0;
    push("post_edge_disp", 3, 12);
    drain();

    readReg1 = 3;
    push("comb_rd1", 1, 12); push("comb_rd2", 2, 0);
    drain();

    // Reset acts only on the edge.
    reset = 1;
    push("reset_pending_disp", 3, 12);
    drain();
    tick();
    reset = 0;
    push("reset_done_disp", 3, 0);
    drain();

    writeReg = 0; writeData = 32'hFFFF_FFFF; regWrite = 1;
    tick();
    regWrite = 0; readReg1 = 0;
    push("reg0_rd1", 1, 0);
    drain();

    reset = 1; regWrite = 1; writeReg = 5; writeData = 7;
    tick();
    reset = 0; regWrite = 0; readReg1 = 5;
    push("reset_prio_rd1", 1, 0);
    drain();

    writeReg = 31; writeData = 32'hA5A5_A5A5; regWrite = 1;
    tick();
    regWrite = 0; readReg1 = 31; readReg2 = 31; displayReg = 31;
    push("r31_rd1", 1, 32'hA5A5_A5A5);
    push("r31_rd2", 2, 32'hA5A5_A5A5);
    push("r31_disp", 3, 32'hA5A5_A5A5);
    drain();

    // Pending overwrite of 31 must not forward.
    writeData = 32'h1234_5678; regWrite = 1;
    push("no_fwd_rd1", 1, 32'hA5A5_A5A5);
    drain();
    tick();
    regWrite = 0;
    push("fwd_after_rd1", 1, 32'h1234_5678);
    drain();

    // Mid-cycle glitch on write controls must leave state alone.
    @(negedge clk);
    writeReg = 7; writeData = 32'hDEAD_BEEF; regWrite = 1;
    #2;
    regWrite = 0;
    tick();
    readReg1 = 7;
    push("glitch_rd1", 1, 0);
    drain();

    // Random writes followed by a sweep of all indices on all ports.
    for (int n = 0; n < 40; n++) begin
      writeReg  = 5'($urandom_range(0, 31));
      writeData = $urandom;
      regWrite  = 1'($urandom_range(0, 1));
      tick();
    end
    regWrite = 0;
    for (int i = 0; i < 32; i++) begin
      readReg1   = 5'(i);
      readReg2   = 5'(31 - i);
      displayReg = 5'((i * 7) % 32);
      push_model("sweep");
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
